// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state type, constants and config-word builder for the LTC2308 capture block
package adc_pkg;

  localparam int NUM_SAMPLES = 128;
  localparam int ADDR_W      = $clog2(NUM_SAMPLES);
  localparam int SAMPLE_W    = 12;
  localparam int CFG_W       = 6;

  localparam logic CFG_SD  = 1'b1;
  localparam logic CFG_UNI = 1'b1;
  localparam logic CFG_SLP = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    CONV_HI,
    CONV_WAIT,
    SHIFT,
    STORE,
    GAP,
    DONE
  } state_t;

  // LTC2308 din word, MSB first: S/D, O/S, S1, S0, UNI, SLP
  function automatic logic [CFG_W-1:0] build_cfg(input logic [2:0] ch);
    return {CFG_SD, ch[0], ch[2], ch[1], CFG_UNI, CFG_SLP};
  endfunction

endpackage

// File: rtl/adc_ltc2308_capture_if.sv
// rtl/adc_ltc2308_capture_if.sv - ADC pins, capture control and sample-RAM write port
interface adc_ltc2308_capture_if;
  import adc_pkg::*;

  logic                start;
  logic [2:0]          cfg_channel;
  logic                spi_sdo;
  logic                spi_sdi;
  logic                spi_scl;
  logic                CONVST;
  logic [ADDR_W-1:0]   sample_addr;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_we;
  logic                busy;
  logic                done;

  modport master (
    input  start, cfg_channel, spi_sdo,
    output spi_sdi, spi_scl, CONVST, sample_addr, sample_data, sample_we, busy, done
  );

  modport slave (
    output start, cfg_channel, spi_sdo,
    input  spi_sdi, spi_scl, CONVST, sample_addr, sample_data, sample_we, busy, done
  );

endinterface

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SCK generator with 6-bit config shift-out and 12-bit result shift-in
module spi_shift_engine
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_go,
  input  logic [CFG_W-1:0]    i_cfg,
  input  logic                i_sdo,
  output logic                o_sck,
  output logic                o_sdi,
  output logic                o_fin,
  output logic [SAMPLE_W-1:0] o_data
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_BIT = 4'(SAMPLE_W - 1);

  logic                r_active;
  logic [DIV_W-1:0]    r_div;
  logic [3:0]          r_bit;
  logic                r_sck;
  logic                r_sdi;
  logic [CFG_W-1:0]    r_cfg;
  logic [SAMPLE_W-1:0] r_shift;
  logic                w_phase_end;

  assign w_phase_end = r_active && (r_div == DIV_LAST);

  // Zero-fill on r_cfg makes sdi fall to 0 by itself once the six config bits are out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sck    <= 1'b0;
      r_sdi    <= 1'b0;
      r_cfg    <= '0;
      r_shift  <= '0;
    end else if (i_go) begin
      r_active <= 1'b1;
      r_div    <= '0;
      r_bit    <= '0;
      r_sck    <= 1'b0;
      r_sdi    <= i_cfg[CFG_W-1];
      r_cfg    <= {i_cfg[CFG_W-2:0], 1'b0};
    end else if (r_active) begin
      if (w_phase_end) begin
        r_div <= '0;
        if (!r_sck) begin
          r_sck   <= 1'b1;
          r_shift <= {r_shift[SAMPLE_W-2:0], i_sdo};
        end else begin
          r_sck <= 1'b0;
          r_sdi <= r_cfg[CFG_W-1];
          r_cfg <= {r_cfg[CFG_W-2:0], 1'b0};
          if (r_bit == LAST_BIT) begin
            r_active <= 1'b0;
          end else begin
            r_bit <= r_bit + 4'd1;
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_fin  = w_phase_end && r_sck && (r_bit == LAST_BIT);
  assign o_sck  = r_sck;
  assign o_sdi  = r_sdi;
  assign o_data = r_shift;

endmodule

// File: rtl/adc_ltc2308_capture.sv
// rtl/adc_ltc2308_capture.sv - LTC2308 capture sequencer: dummy conversion then NUM_SAMPLES stored results
module adc_ltc2308_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int GAP_CYCLES  = 19
) (
  input logic                   ref_clk,
  input logic                   reset_n,
  adc_ltc2308_capture_if.master bus
);

  localparam int CNT_MAX = (CONV_CYCLES > GAP_CYCLES) ? CONV_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CONVST_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(NUM_SAMPLES - 1);

  state_t              r_state;
  state_t              w_state_n;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_start_d;
  logic                w_start_rise;
  logic [2:0]          r_channel;
  logic                r_dummy;
  logic [ADDR_W-1:0]   r_addr;
  logic [SAMPLE_W-1:0] r_data;
  logic                r_we;
  logic                r_convst;
  logic                r_busy;
  logic                r_done;
  logic                w_go;
  logic                w_fin;
  logic                w_sck;
  logic                w_sdi;
  logic                w_store_we;
  logic [CFG_W-1:0]    w_cfg;
  logic [SAMPLE_W-1:0] w_shift_data;

  assign w_start_rise = bus.start & ~r_start_d;
  assign w_cfg        = build_cfg(r_channel);
  assign w_store_we   = (w_state_n == STORE) && !r_dummy;

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= (w_state_n != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_go      = 1'b0;
    case (r_state)
      IDLE:      if (w_start_rise) w_state_n = CONV_HI;
      CONV_HI:   if (r_cnt == CONVST_LAST) w_state_n = CONV_WAIT;
      CONV_WAIT: begin
        if (r_cnt == CONV_LAST) begin
          w_state_n = SHIFT;
          w_go      = 1'b1;
        end
      end
      SHIFT:     if (w_fin) w_state_n = STORE;
      STORE:     w_state_n = (!r_dummy && (r_addr == ADDR_LAST)) ? DONE : GAP;
      GAP:       if (r_cnt == GAP_LAST) w_state_n = CONV_HI;
      DONE:      w_state_n = IDLE;
      default:   w_state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_d <= 1'b0;
      r_channel <= '0;
      r_dummy   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_convst  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_start_d <= bus.start;
      r_convst  <= (w_state_n == CONV_HI);
      r_busy    <= (w_state_n != IDLE);
      r_done    <= (w_state_n == DONE);
      r_we      <= w_store_we;
      if (w_store_we) begin
        r_data <= w_shift_data;
      end
      if ((r_state == IDLE) && w_start_rise) begin
        r_channel <= bus.cfg_channel;
        r_dummy   <= 1'b1;
      end
      // The last address is held through DONE so the wrap to 0 only happens on the way to IDLE.
      if (r_state == STORE) begin
        r_dummy <= 1'b0;
        if (!r_dummy && (r_addr != ADDR_LAST)) begin
          r_addr <= r_addr + 1'b1;
        end
      end
      if (r_state == DONE) begin
        r_addr <= '0;
      end
    end
  end

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk    (ref_clk),
    .rst_n  (reset_n),
    .i_go   (w_go),
    .i_cfg  (w_cfg),
    .i_sdo  (bus.spi_sdo),
    .o_sck  (w_sck),
    .o_sdi  (w_sdi),
    .o_fin  (w_fin),
    .o_data (w_shift_data)
  );

  assign bus.spi_scl     = w_sck;
  assign bus.spi_sdi     = w_sdi;
  assign bus.CONVST      = r_convst;
  assign bus.sample_addr = r_addr;
  assign bus.sample_data = r_data;
  assign bus.sample_we   = r_we;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
